sb_trig_scaler: RTL and testbench



---
 rtl/sb_trig_scaler_pkg.sv | 32 +++
 rtl/sb_sat_counter.sv | 49 ++++
 rtl/sb_trig_scaler.sv | 199 +++++++++++++++++++
 tb/tb_sb_trig_scaler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_trig_scaler_pkg.sv
// Shared definitions for the single-bin trigger scaler: register field layout,
// default counter width and the scaler FSM state encodings.
package sb_trig_scaler_pkg;

    // Default width of the running and latched rate counters
    localparam int SB_CNT_WIDTH_DEFAULT = 24;

    // PS control word layout: PRESCALE in the low byte, HOLDOFF above it
    localparam int SB_PRESCALE_SHIFT = 0;
    localparam int SB_PRESCALE_WIDTH = 8;
    localparam int SB_HOLDOFF_SHIFT  = 8;
    localparam int SB_HOLDOFF_WIDTH  = 16;

    // Scaler FSM: IDLE accepts edges, HOLDOFF is the post-trigger dead time
    typedef enum logic [0:0] {
        SB_SCALER_IDLE    = 1'b0,
        SB_SCALER_HOLDOFF = 1'b1
    } sbScalerState_e;

    // Builds a PS control word from the two settings (used by software models)
    function automatic logic [31:0] sbPackConfig(
        input logic [SB_PRESCALE_WIDTH-1:0] prescale,
        input logic [SB_HOLDOFF_WIDTH-1:0]  holdoff
    );
        logic [31:0] word;
        word = '0;
        word[SB_PRESCALE_SHIFT +: SB_PRESCALE_WIDTH] = prescale;
        word[SB_HOLDOFF_SHIFT +: SB_HOLDOFF_WIDTH]   = holdoff;
        return word;
    endfunction

endpackage

// File: rtl/sb_sat_counter.sv
// Saturating event counter with sticky overflow flag. A clear that coincides
// with an increment loads 1 so the event lands in the new interval.
module sb_sat_counter #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_load_i,
    output logic [WIDTH-1:0] value_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] value_q, value_d;
    logic             sat_q, sat_d;

    // Next value: clear/load-1, saturating increment, or hold
    always_comb begin
        value_d = value_q;
        sat_d   = sat_q;
        if (clr_load_i) begin
            value_d = {{(WIDTH-1){1'b0}}, inc_i};
            sat_d   = 1'b0;
        end else if (inc_i) begin
            if (value_q == ALL_ONES) begin
                sat_d = 1'b1;
            end else begin
                value_d = value_q + WIDTH'(1);
            end
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value_o = value_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/sb_trig_scaler.sv
// Single-bin trigger scaler: edge-detects TRIG_IN, applies prescale and a
// post-trigger holdoff, forwards a one-cycle TRIG_OUT and keeps per-PPS
// raw/forwarded rate counts for the PS.
// Optional build macro SB_SCALER_DEADTIME_EN adds the DEAD_TIME output that
// counts CLK120 cycles spent in HOLDOFF per PPS interval.
module sb_trig_scaler
    import sb_trig_scaler_pkg::*;
#(
    parameter int CNT_WIDTH      = SB_CNT_WIDTH_DEFAULT,
    parameter int PRESCALE_WIDTH = SB_PRESCALE_WIDTH,
    parameter int HOLDOFF_WIDTH  = SB_HOLDOFF_WIDTH
) (
    input  logic                      CLK120,
    input  logic                      RESET_N,
    input  logic                      TRIG_IN,
    input  logic                      PPS,
    input  logic                      ENABLE,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic [HOLDOFF_WIDTH-1:0]  HOLDOFF,
    output logic                      TRIG_OUT,
    output logic [CNT_WIDTH-1:0]      RAW_RATE,
    output logic [CNT_WIDTH-1:0]      ACC_RATE,
    output logic                      RATE_OVF,
    output logic                      RATE_VALID,
    output logic                      BUSY
`ifdef SB_SCALER_DEADTIME_EN
    ,
    output logic [CNT_WIDTH-1:0]      DEAD_TIME
`endif
);

    logic trigSync_q, trigPrev_q;
    logic ppsSync_q, ppsPrev_q;
    logic trigEdge, ppsEdge, qualEdge;

    sbScalerState_e            state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0]  holdCnt_q, holdCnt_d;
    logic [PRESCALE_WIDTH-1:0] prescaleCnt_q, prescaleCnt_d;
    logic                      trigOut_q, trigOut_d;
    logic                      accInc;

    logic [CNT_WIDTH-1:0] rawCnt, accCnt;
    logic                 rawSat, accSat;
    logic                 ovfFlag;

    logic [CNT_WIDTH-1:0] rawRate_q, accRate_q;
    logic                 rateOvf_q, rateValid_q;

    // Input register plus one-cycle history so both inputs are level-tolerant
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            trigSync_q <= 1'b0;
            trigPrev_q <= 1'b0;
            ppsSync_q  <= 1'b0;
            ppsPrev_q  <= 1'b0;
        end else begin
            trigSync_q <= TRIG_IN;
            trigPrev_q <= trigSync_q;
            ppsSync_q  <= PPS;
            ppsPrev_q  <= ppsSync_q;
        end
    end

    assign trigEdge = trigSync_q & ~trigPrev_q;
    assign ppsEdge  = ppsSync_q & ~ppsPrev_q;
    assign qualEdge = trigEdge & ENABLE;

    // Next-state logic: prescale/forward decision in IDLE, dead-time countdown in HOLDOFF
    always_comb begin
        state_d       = state_q;
        holdCnt_d     = holdCnt_q;
        prescaleCnt_d = prescaleCnt_q;
        trigOut_d     = 1'b0;
        accInc        = 1'b0;
        if (!ENABLE) begin
            state_d       = SB_SCALER_IDLE;
            holdCnt_d     = '0;
            prescaleCnt_d = '0;
        end else begin
            case (state_q)
                SB_SCALER_IDLE: begin
                    if (qualEdge) begin
                        if (prescaleCnt_q == PRESCALE) begin
                            trigOut_d     = 1'b1;
                            accInc        = 1'b1;
                            prescaleCnt_d = '0;
                            if (HOLDOFF != '0) begin
                                holdCnt_d = HOLDOFF;
                                state_d   = SB_SCALER_HOLDOFF;
                            end
                        end else begin
                            prescaleCnt_d = prescaleCnt_q + PRESCALE_WIDTH'(1);
                        end
                    end
                end
                SB_SCALER_HOLDOFF: begin
                    holdCnt_d = holdCnt_q - HOLDOFF_WIDTH'(1);
                    if (holdCnt_q == HOLDOFF_WIDTH'(1)) begin
                        state_d = SB_SCALER_IDLE;
                    end
                end
                default: begin
                    state_d   = SB_SCALER_IDLE;
                    holdCnt_d = '0;
                end
            endcase
        end
    end

    // FSM state, counters and the registered forwarded trigger
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= SB_SCALER_IDLE;
            holdCnt_q     <= '0;
            prescaleCnt_q <= '0;
            trigOut_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdCnt_q     <= holdCnt_d;
            prescaleCnt_q <= prescaleCnt_d;
            trigOut_q     <= trigOut_d;
        end
    end

    sb_sat_counter #(.WIDTH(CNT_WIDTH)) rawCounter (
        .clk_i      (CLK120),
        .rst_ni     (RESET_N),
        .inc_i      (qualEdge),
        .clr_load_i (ppsEdge),
        .value_o    (rawCnt),
        .sat_o      (rawSat)
    );

    sb_sat_counter #(.WIDTH(CNT_WIDTH)) accCounter (
        .clk_i      (CLK120),
        .rst_ni     (RESET_N),
        .inc_i      (accInc),
        .clr_load_i (ppsEdge),
        .value_o    (accCnt),
        .sat_o      (accSat)
    );

`ifdef SB_SCALER_DEADTIME_EN
    logic [CNT_WIDTH-1:0] deadCnt, deadRate_q;
    logic                 deadSat;
    logic                 deadInc;

    assign deadInc = ENABLE & (state_q == SB_SCALER_HOLDOFF);

    sb_sat_counter #(.WIDTH(CNT_WIDTH)) deadCounter (
        .clk_i      (CLK120),
        .rst_ni     (RESET_N),
        .inc_i      (deadInc),
        .clr_load_i (ppsEdge),
        .value_o    (deadCnt),
        .sat_o      (deadSat)
    );

    assign ovfFlag = rawSat | accSat | deadSat;

    // Latch the dead-time count alongside the rate counters on each PPS edge
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            deadRate_q <= '0;
        end else if (ppsEdge) begin
            deadRate_q <= deadCnt;
        end
    end

    assign DEAD_TIME = deadRate_q;
`else
    assign ovfFlag = rawSat | accSat;
`endif

    // Latch rates on each PPS edge and flag the update one cycle later
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            rawRate_q   <= '0;
            accRate_q   <= '0;
            rateOvf_q   <= 1'b0;
            rateValid_q <= 1'b0;
        end else begin
            rateValid_q <= ppsEdge;
            if (ppsEdge) begin
                rawRate_q <= rawCnt;
                accRate_q <= accCnt;
                rateOvf_q <= ovfFlag;
            end
        end
    end

    assign TRIG_OUT   = trigOut_q;
    assign RAW_RATE   = rawRate_q;
    assign ACC_RATE   = accRate_q;
    assign RATE_OVF   = rateOvf_q;
    assign RATE_VALID = rateValid_q;
    assign BUSY       = (state_q == SB_SCALER_HOLDOFF);

endmodule

// File: tb/tb_sb_trig_scaler.sv
// Scoreboard bench for sb_trig_scaler: a default-width DUT and a 4-bit-counter
// DUT share all inputs; expected triggers and rate snapshots are queued when
// stimulus is driven and compared when the DUTs produce them.
module tb_sb_trig_scaler;

    localparam int CW   = 24;
    localparam int NW   = 4;
    localparam int NMAX = 15;

    typedef struct {
        int cyc;
        int raw;
        int acc;
    } rateExp_t;

    logic clk;
    logic resetN, trigIn, pps, enable;
    logic [7:0]  prescale;
    logic [15:0] holdoff;

    logic          trigOut, rateOvf, rateValid, busy;
    logic [CW-1:0] rawRate, accRate;
    logic          nTrigOut, nRateOvf, nRateValid, nBusy;
    logic [NW-1:0] nRawRate, nAccRate;
`ifdef SB_SCALER_DEADTIME_EN
    logic [CW-1:0] deadTime;
    logic [NW-1:0] nDeadTime;
`endif

    int       checkCount = 0;
    int       errorCount = 0;
    int       cyc = 0;
    int       expRaw = 0;
    int       expAcc = 0;
    int       busyRun = 0;
    int       holdSetting = 0;
    bit       checkBusy = 0;
    bit       trigExp, rateExp;
    int       trigQ[$];
    rateExp_t rateQ[$];
    rateExp_t cur;

    sb_trig_scaler #(.CNT_WIDTH(CW)) dut (
        .CLK120     (clk),
        .RESET_N    (resetN),
        .TRIG_IN    (trigIn),
        .PPS        (pps),
        .ENABLE     (enable),
        .PRESCALE   (prescale),
        .HOLDOFF    (holdoff),
        .TRIG_OUT   (trigOut),
        .RAW_RATE   (rawRate),
        .ACC_RATE   (accRate),
        .RATE_OVF   (rateOvf),
        .RATE_VALID (rateValid),
        .BUSY       (busy)
`ifdef SB_SCALER_DEADTIME_EN
        ,
        .DEAD_TIME  (deadTime)
`endif
    );

    sb_trig_scaler #(.CNT_WIDTH(NW)) dutNarrow (
        .CLK120     (clk),
        .RESET_N    (resetN),
        .TRIG_IN    (trigIn),
        .PPS        (pps),
        .ENABLE     (enable),
        .PRESCALE   (prescale),
        .HOLDOFF    (holdoff),
        .TRIG_OUT   (nTrigOut),
        .RAW_RATE   (nRawRate),
        .ACC_RATE   (nAccRate),
        .RATE_OVF   (nRateOvf),
        .RATE_VALID (nRateValid),
        .BUSY       (nBusy)
`ifdef SB_SCALER_DEADTIME_EN
        ,
        .DEAD_TIME  (nDeadTime)
`endif
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    function automatic int satN(input int v);
        return (v > NMAX) ? NMAX : v;
    endfunction

    // Drives a one-cycle TRIG_IN pulse and queues the outcome the bench predicts
    task automatic applyStimulus(input bit counted, input bit fwd);
        @(negedge clk);
        trigIn = 1'b1;
        if (counted) expRaw++;
        if (fwd) begin
            expAcc++;
            trigQ.push_back(cyc + 2);
        end
        @(negedge clk);
        trigIn = 1'b0;
    endtask

    // Drives a PPS pulse, optionally with a simultaneous trigger edge
    task automatic doPps(input bit withTrig);
        rateExp_t e;
        @(negedge clk);
        pps   = 1'b1;
        e.cyc = cyc + 2;
        e.raw = expRaw;
        e.acc = expAcc;
        rateQ.push_back(e);
        expRaw = 0;
        expAcc = 0;
        if (withTrig) begin
            trigIn = 1'b1;
            trigQ.push_back(cyc + 2);
            expRaw = 1;
            expAcc = 1;
        end
        @(negedge clk);
        pps    = 1'b0;
        trigIn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Loads new settings with a short ENABLE-low gap that clears the prescaler
    task automatic setConfig(input logic [7:0] p, input logic [15:0] h);
        @(negedge clk);
        enable   = 1'b0;
        prescale = p;
        holdoff  = h;
        repeat (2) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_trig_out"}, 32'(trigOut), 32'd0);
        checkOutput({phase, "_busy"}, 32'(busy), 32'd0);
        checkOutput({phase, "_n_busy"}, 32'(nBusy), 32'd0);
        checkOutput({phase, "_raw_rate"}, 32'(rawRate), 32'd0);
        checkOutput({phase, "_acc_rate"}, 32'(accRate), 32'd0);
        checkOutput({phase, "_rate_ovf"}, 32'(rateOvf), 32'd0);
        checkOutput({phase, "_rate_valid"}, 32'(rateValid), 32'd0);
`ifdef SB_SCALER_DEADTIME_EN
        checkOutput({phase, "_dead_time"}, 32'(deadTime), 32'd0);
`endif
    endtask

    // Scoreboard: compare trigger and rate outputs every cycle, track BUSY run length
    always @(negedge clk) begin
        if (resetN) begin
            trigExp = (trigQ.size() > 0) && (trigQ[0] == cyc);
            checkOutput("trig_out", 32'(trigOut), 32'(trigExp));
            checkOutput("n_trig_out", 32'(nTrigOut), 32'(trigExp));
            if (trigExp) void'(trigQ.pop_front());

            rateExp = (rateQ.size() > 0) && (rateQ[0].cyc == cyc);
            checkOutput("rate_valid", 32'(rateValid), 32'(rateExp));
            checkOutput("n_rate_valid", 32'(nRateValid), 32'(rateExp));
            if (rateExp) begin
                cur = rateQ.pop_front();
                checkOutput("raw_rate", 32'(rawRate), 32'(cur.raw));
                checkOutput("acc_rate", 32'(accRate), 32'(cur.acc));
                checkOutput("rate_ovf", 32'(rateOvf), 32'd0);
                checkOutput("n_raw_rate", 32'(nRawRate), 32'(satN(cur.raw)));
                checkOutput("n_acc_rate", 32'(nAccRate), 32'(satN(cur.acc)));
                checkOutput("n_rate_ovf", 32'(nRateOvf), 32'((cur.raw > NMAX) || (cur.acc > NMAX)));
            end

            if (busy) begin
                busyRun++;
            end else begin
                if (busyRun != 0 && checkBusy) checkOutput("busy_len", 32'(busyRun), 32'(holdSetting));
                busyRun = 0;
            end
        end
    end

    initial begin
        resetN   = 1'b1;
        trigIn   = 1'b0;
        pps      = 1'b0;
        enable   = 1'b0;
        prescale = 8'd0;
        holdoff  = 16'd0;
        #1 resetN = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        resetN = 1'b1;

        // Prescale 0, no holdoff: every pulse forwarded
        setConfig(8'd0, 16'd0);
        doPps(1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1);
            idle(1);
        end
        doPps(1'b0);

        // Prescale 3: forward pulses 4 and 8 of 10
        setConfig(8'd3, 16'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i % 4) == 3);
            idle(1);
        end
        doPps(1'b0);

        // ENABLE low: no counting, no forwarding, PPS latching continues
        @(negedge clk);
        enable = 1'b0;
        applyStimulus(1'b0, 1'b0);
        idle(3);
        doPps(1'b0);

        // Holdoff 5: edges at +3 and +5 rejected, edge at +6 accepted
        setConfig(8'd0, 16'd5);
        holdSetting = 5;
        checkBusy   = 1'b1;
        applyStimulus(1'b1, 1'b1);
        idle(1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idle(10);
        applyStimulus(1'b1, 1'b1);
        idle(4);
        applyStimulus(1'b1, 1'b1);
        idle(10);
        checkBusy = 1'b0;
        doPps(1'b0);

        // Held-high TRIG_IN counts once; trigger on the PPS edge starts the new interval at 1
        setConfig(8'd0, 16'd0);
        @(negedge clk);
        trigIn = 1'b1;
        trigQ.push_back(cyc + 2);
        expRaw++;
        expAcc++;
        repeat (20) @(negedge clk);
        trigIn = 1'b0;
        idle(3);
        doPps(1'b1);
        doPps(1'b0);

        // 17 pulses saturate the narrow counters; next interval is clean
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b1);
            idle(1);
        end
        doPps(1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1);
            idle(1);
        end
        doPps(1'b0);

        // Asynchronous reset two cycles into a long holdoff window
        setConfig(8'd0, 16'd100);
        applyStimulus(1'b1, 1'b1);
        idle(3);
        #2 resetN = 1'b0;
        #1;
        checkAllZero("async_reset");
        checkOutput("trig_q_at_reset", 32'(trigQ.size()), 32'd0);
        trigQ.delete();
        rateQ.delete();
        expRaw = 0;
        expAcc = 0;
        idle(2);
        resetN = 1'b1;
        idle(2);
        applyStimulus(1'b1, 1'b1);
        idle(4);

        checkOutput("trig_q_left", 32'(trigQ.size()), 32'd0);
        checkOutput("rate_q_left", 32'(rateQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
